load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the bus wait-cycle limit before fault; legal range 1..255.
REQ-002 clk  in  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  SHALL be an asynchronous, active-low reset.
REQ-004 mem_read  in  1  SHALL mean the current instruction is a load (from control decode).
REQ-005 mem_write  in  1  SHALL mean the current instruction is a store.
REQ-006 funct3  in  3  SHALL give access width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 addr  in  32  SHALL be the effective byte address from the ALU.
REQ-008 store_data  in  32  SHALL be the rs2 value.
REQ-009 stall  out  1  SHALL, when high, hold the PC and suppress register writeback.
REQ-010 load_data  out  32  SHALL be the extended load result.
REQ-011 fault  out  1  SHALL be a one-cycle access-fault flag; fault_code  out  2  SHALL qualify it: 01 misaligned, 10 bus timeout, 11 illegal op.
REQ-012 bus_req, bus_we  out  1 each; bus_addr, bus_wdata  out  32 each; bus_be  out  4  SHALL form the data-memory request.
REQ-013 bus_ack  in  1; bus_rdata  in  32  SHALL be the memory completion and read data.

Function
REQ-014 The FSM SHALL have states IDLE, REQ, DONE, ERR; reset state IDLE.
REQ-015 IDLE, no memory op (mem_read=mem_write=0): stall=0, stay IDLE.
REQ-016 IDLE with a memory op: stall=1 combinationally; next state per REQ-017..019.
REQ-017 Illegal op (both mem_read and mem_write high, load funct3 in {011,110,111}, or store funct3 >= 011) SHALL go to ERR with code 11.
REQ-018 Misaligned access (H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=00) SHALL go to ERR with code 01; no bus request is issued.
REQ-019 Otherwise SHALL go to REQ, registering bus_addr={addr[31:2],2'b00}, bus_we=mem_write, bus_be, bus_wdata, funct3, addr[1:0].
REQ-020 bus_be SHALL be: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
REQ-021 bus_wdata SHALL be: SB byte replicated to four lanes; SH halfword replicated to two lanes; SW store_data unchanged.
REQ-022 REQ: bus_req=1, stall=1; all bus outputs SHALL stay stable until bus_ack.
REQ-023 REQ with bus_ack=1 SHALL go to DONE; for loads, load_data SHALL capture the selected lane of bus_rdata, sign-extended (B, H) or zero-extended (BU, HU); W unchanged.
REQ-024 A wait counter SHALL clear on REQ entry and increment each REQ cycle without ack; reaching TIMEOUT without ack SHALL go to ERR with code 10 and drop bus_req.
REQ-025 Ack in the same cycle the counter reaches TIMEOUT SHALL take precedence (go to DONE).
REQ-026 DONE: stall=0, bus_req=0; go to IDLE unconditionally; the still-present instruction SHALL NOT start a second access.
REQ-027 ERR: stall=0, fault=1 with latched fault_code; go to IDLE unconditionally.
REQ-028 bus_ack outside REQ SHALL be ignored.
REQ-029 load_data SHALL hold its value until the next completed load; stores and faults SHALL NOT change it.
REQ-030 Minimum latency: a zero-wait memory op SHALL take 3 cycles (IDLE, REQ, DONE) with stall high for the first 2.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, with bus_req=0, bus_we=0, bus_be=0000, bus_addr=0, bus_wdata=0, load_data=0, fault=0, fault_code=00, counter=0; stall follows REQ-015/016.
REQ-032 Reset asserted during REQ SHALL abort the access with no DONE or fault; after release, operation SHALL restart from IDLE.

Verification
REQ-033 LB, addr=0x1003, bus_rdata=0x80FF_FF7F, ack in first REQ cycle -> bus_be=1000, load_data=0xFFFF_FF80, stall high 2 cycles, then low.
REQ-034 SH, addr=0x2002, store_data=0x1234_ABCD -> bus_be=1100, bus_wdata=0xABCD_ABCD, bus_we=1, load_data unchanged.
REQ-035 LW, addr=0x3001 -> no bus_req, fault=1 code 01 for exactly one cycle.
REQ-036 LHU, addr=0x0002, ack withheld, TIMEOUT=4 -> bus_req high 4 cycles, then fault code 10; ack on cycle 4 -> DONE, no fault.
REQ-037 mem_read held high across DONE with zero-wait memory -> exactly one bus_req pulse per instruction.
REQ-038 rst_n low mid-REQ -> bus_req 0 immediately; no fault or load_data update.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Data-memory request/response bus between the load/store unit and memory.
interface load_store_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
                  input  bus_ack, bus_rdata);
  modport slave  (input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
                  output bus_ack, bus_rdata);
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: decodes a memory op, checks legality/alignment, runs one
// bus transaction with a wait-cycle timeout and extends load results.
module load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        fault,
  output logic [1:0]  fault_code,
  load_store_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  typedef struct packed {
    logic [2:0] f3;
    logic [1:0] alo;
  } req_t;

  state_t      state, nxt;
  req_t        rq;
  logic [7:0]  cnt;
  logic        op, illegal, misal, cnt_hit;
  logic [3:0]  be_n;
  logic [31:0] wd_n, lane, ld_ext;

  assign op      = mem_read | mem_write;
  assign illegal = (mem_read & mem_write)
                 | (mem_read & (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111))
                 | (mem_write & (funct3 >= 3'b011));
  // funct3[1:0] carries the width for both signed and unsigned loads
  assign misal   = ((funct3[1:0] == 2'b01) & addr[0])
                 | ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
  assign cnt_hit = (cnt == 8'(TIMEOUT - 1));

  always_comb begin
    be_n = 4'b1111;
    wd_n = store_data;
    case (funct3[1:0])
      2'b00: begin be_n = 4'b0001 << addr[1:0]; wd_n = {4{store_data[7:0]}};  end
      2'b01: begin be_n = 4'b0011 << addr[1:0]; wd_n = {2{store_data[15:0]}}; end
      default: ;
    endcase
  end

  assign lane = bus.bus_rdata >> {rq.alo, 3'b000};
  always_comb begin
    ld_ext = bus.bus_rdata;
    case (rq.f3)
      3'b000: ld_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001: ld_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100: ld_ext = {24'd0, lane[7:0]};
      3'b101: ld_ext = {16'd0, lane[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (op) nxt = (illegal | misal) ? ERR : REQ;
      REQ:     if (bus.bus_ack) nxt = DONE;
               else if (cnt_hit) nxt = ERR;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    stall       = 1'b0;
    bus.bus_req = 1'b0;
    fault       = 1'b0;
    case (state)
      IDLE:    stall = op;
      REQ:     begin stall = 1'b1; bus.bus_req = 1'b1; end
      ERR:     fault = 1'b1;
      default: ;
    endcase
  end

  // Bus outputs are latched at request launch and held until the access ends.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.bus_addr  <= '0;
      bus.bus_we    <= 1'b0;
      bus.bus_be    <= '0;
      bus.bus_wdata <= '0;
      load_data     <= '0;
      fault_code    <= '0;
      cnt           <= '0;
      rq            <= '0;
    end else begin
      case (state)
        IDLE: if (op) begin
          if (illegal)    fault_code <= 2'b11;
          else if (misal) fault_code <= 2'b01;
          else begin
            bus.bus_addr  <= {addr[31:2], 2'b00};
            bus.bus_we    <= mem_write;
            bus.bus_be    <= be_n;
            bus.bus_wdata <= wd_n;
            rq            <= '{f3: funct3, alo: addr[1:0]};
            cnt           <= '0;
          end
        end
        REQ: if (bus.bus_ack) begin
          if (!bus.bus_we) load_data <= ld_ext;
        end else begin
          cnt <= cnt + 8'd1;
          if (cnt_hit) fault_code <= 2'b10;
        end
        default: ;
      endcase
    end

endmodule
